mode_controller: RTL

- Front-panel controller upstream of the lower top-level.
- Synchronises and debounces three raw push-buttons: power, sleep and atmospheric.
- Runs the system mode FSM and drives the sysOn, sleep and atmospheric inputs of the air-conditioning/lights stage.
- All outputs are registered and level-held, so downstream sees clean, glitch-free mode signals.

---
 rtl/mode_controller_if.sv | 22 ++
 rtl/mode_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mode_controller_if.sv
// Front-panel bus for mode_controller: raw push-buttons in, level-held mode signals out.
interface mode_controller_if;
  logic       btn_power;
  logic       btn_sleep;
  logic       btn_atmos;
  logic       sysOn;
  logic       sleep;
  logic       atmospheric;
  logic [1:0] mode;

  // Panel/stimulus side: drives the buttons, observes the mode signals.
  modport master (
    output btn_power, btn_sleep, btn_atmos,
    input  sysOn, sleep, atmospheric, mode
  );

  // Controller side.
  modport slave (
    input  btn_power, btn_sleep, btn_atmos,
    output sysOn, sleep, atmospheric, mode
  );
endinterface

// File: rtl/mode_controller.sv
// mode_controller: synchronises and debounces the power/sleep/atmospheric buttons,
// runs the OFF/ON/SLEEP mode FSM and drives registered, level-held mode outputs.
// Optional feature macro: MODE_CTRL_AUTO_SLEEP_EN (idle timeout from ON into SLEEP).
module mode_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int IDLE_TIMEOUT    = 1000
) (
  input  logic           clk,
  input  logic           rst,
  mode_controller_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Both parameters must be at least 1 or the counters have no terminal value.
  if (DEBOUNCE_CYCLES < 1 || IDLE_TIMEOUT < 1) begin : g_bad_param
    $error("mode_controller: DEBOUNCE_CYCLES and IDLE_TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_ON    = 2'b01,
    S_SLEEP = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  // Button index: 0 = power, 1 = sleep, 2 = atmospheric.
  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_stable;
  logic [2:0]    r_press;
  logic [CW-1:0] r_cnt [3];

  logic   w_p;
  logic   w_s;
  logic   w_a;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_atmos;
  logic   w_atmos_nxt;
  logic   r_sys_on;
  logic   r_sleep;
  logic [1:0] r_mode;

`ifdef MODE_CTRL_AUTO_SLEEP_EN
  localparam int IW = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
  logic [IW-1:0] r_idle;
  logic [IW-1:0] w_idle_nxt;
`endif

  assign w_raw = {bus.btn_atmos, bus.btn_sleep, bus.btn_power};
  assign w_p   = r_press[0];
  assign w_s   = r_press[1];
  assign w_a   = r_press[2];

  // Two-flop synchronisers, per-button debounce counters and rising-edge press pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 3'b000;
      r_sync2  <= 3'b000;
      r_stable <= 3'b000;
      r_press  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i]   <= '0;
          r_press[i] <= 1'b0;
        end else if (r_cnt[i] == CNT_LAST) begin
          // Level accepted; only a newly accepted high level is a press.
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
          r_press[i]  <= r_sync2[i];
        end else begin
          r_cnt[i]   <= r_cnt[i] + CW'(1);
          r_press[i] <= 1'b0;
        end
      end
    end
  end

  // Next-state and atmospheric logic; one press acts per cycle, power > sleep > atmos.
  always_comb begin
    w_state_nxt = r_state;
    w_atmos_nxt = r_atmos;
`ifdef MODE_CTRL_AUTO_SLEEP_EN
    w_idle_nxt  = '0;
`endif
    case (r_state)
      S_OFF: begin
        w_atmos_nxt = 1'b0;
        if (w_p) begin
          w_state_nxt = S_ON;
        end else begin
          w_state_nxt = S_OFF;
        end
      end
      S_ON: begin
        if (w_p) begin
          w_state_nxt = S_OFF;
          w_atmos_nxt = 1'b0;
        end else if (w_s) begin
          w_state_nxt = S_SLEEP;
        end else if (w_a) begin
          w_atmos_nxt = ~r_atmos;
        end else begin
`ifdef MODE_CTRL_AUTO_SLEEP_EN
          if (r_idle == IDLE_LAST) begin
            w_state_nxt = S_SLEEP;
          end else begin
            w_idle_nxt = r_idle + IW'(1);
          end
`else
          w_state_nxt = S_ON;
`endif
        end
      end
      S_SLEEP: begin
        if (w_p) begin
          w_state_nxt = S_OFF;
          w_atmos_nxt = 1'b0;
        end else if (w_s) begin
          w_state_nxt = S_ON;
        end else begin
          w_state_nxt = S_SLEEP;
        end
      end
      default: begin
        // Unused encoding: fall back to the safe OFF state.
        w_state_nxt = S_OFF;
        w_atmos_nxt = 1'b0;
      end
    endcase
  end

  // State register and registered output decode taken from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_OFF;
      r_atmos  <= 1'b0;
      r_sys_on <= 1'b0;
      r_sleep  <= 1'b0;
      r_mode   <= 2'b00;
    end else begin
      r_state  <= w_state_nxt;
      r_atmos  <= w_atmos_nxt;
      r_sys_on <= (w_state_nxt != S_OFF);
      r_sleep  <= (w_state_nxt == S_SLEEP);
      r_mode   <= w_state_nxt;
    end
  end

`ifdef MODE_CTRL_AUTO_SLEEP_EN
  // Idle counter: counts press-free edges spent in ON.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle <= '0;
    end else begin
      r_idle <= w_idle_nxt;
    end
  end
`endif

  assign bus.sysOn       = r_sys_on;
  assign bus.sleep       = r_sleep;
  assign bus.atmospheric = r_atmos;
  assign bus.mode        = r_mode;

endmodule
